// File: rtl/pipelined_shifter.sv
// Pipelined log barrel shifter (SLL/SRL/SRA/ROL/ROR) with tag sideband.
// Ports: clk, rst_n, in_valid/in_ready/in_data/in_shamt/in_op/in_tag,
//        out_valid/out_ready/out_data/out_tag/out_illegal.
module pipelined_shifter #(
  parameter  int WIDTH   = 32,
  parameter  int STAGES  = 2,
  parameter  int TAG_W   = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_illegal
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef struct packed {
    logic               valid;
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shamt;
    logic [2:0]         op;
    logic [TAG_W-1:0]   tag;
    logic               ill;
  } stage_t;

  // Level k lives in stage floor(k*STAGES/SHAMT_W); with
  // STAGES <= SHAMT_W every stage gets at least one level.
  function automatic int stage_of(input int k);
    return (k * STAGES) / SHAMT_W;
  endfunction

  function automatic logic [WIDTH-1:0] lvl_shift(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       op,
    input int               k
  );
    logic [WIDTH-1:0] r;
    int amt;
    amt = 1 << k;
    unique case (1'b1)
      op == OP_SLL: r = d << amt;
      op == OP_SRL: r = d >> amt;
      // MSB is preserved by every level, so it is
      // the original sign bit at each step.
      op == OP_SRA: r = WIDTH'($signed(d) >>> amt);
      op == OP_ROL: r = (d << amt) | (d >> (WIDTH - amt));
      op == OP_ROR: r = (d >> amt) | (d << (WIDTH - amt));
      default:      r = d;
    endcase
    return r;
  endfunction

  stage_t r_stg [STAGES];
  stage_t w_src [STAGES];
  stage_t w_nxt [STAGES];
  logic   w_adv;

  // One global stall: everything moves or nothing does.
  assign w_adv    = !r_stg[STAGES-1].valid || out_ready;
  assign in_ready = w_adv;

  always_comb begin
    w_src[0] = '{
      valid: in_valid,
      data:  in_data,
      shamt: in_shamt,
      op:    in_op,
      tag:   in_tag,
      ill:   (in_op > OP_ROR)
    };
    for (int s = 1; s < STAGES; s++)
      w_src[s] = r_stg[s-1];
    for (int s = 0; s < STAGES; s++) begin
      w_nxt[s] = w_src[s];
      for (int k = 0; k < SHAMT_W; k++)
        if (stage_of(k) == s &&
            w_src[s].shamt[k] &&
            !w_src[s].ill)
          w_nxt[s].data = lvl_shift(
            w_nxt[s].data, w_src[s].op, k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++)
        r_stg[s] <= '0;
    end else if (w_adv) begin
      for (int s = 0; s < STAGES; s++)
        r_stg[s] <= w_nxt[s];
    end
  end

  assign out_valid   = r_stg[STAGES-1].valid;
  assign out_data    = r_stg[STAGES-1].data;
  assign out_tag     = r_stg[STAGES-1].tag;
  assign out_illegal = r_stg[STAGES-1].ill;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter at STAGES=2 (main),
// STAGES=1 and STAGES=5 (shared stimulus, out_ready tied high).
module tb_pipelined_shifter;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_valid_x = 0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [2:0]  in_op = '0;
  logic [3:0]  in_tag = '0;
  logic        out_ready = 1;
  logic        one = 1;

  logic        in_ready, o2_v, o2_il;
  logic [31:0] o2_d;
  logic [3:0]  o2_t;
  logic        rdy1, o1_v, o1_il;
  logic [31:0] o1_d;
  logic [3:0]  o1_t;
  logic        rdy5, o5_v, o5_il;
  logic [31:0] o5_d;
  logic [3:0]  o5_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        ill;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q2[$], q1[$], q5[$];
  int   total = 0, bad = 0, cyc = 0;
  bit   lat_chk = 1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(o2_v), .out_ready(out_ready),
    .out_data(o2_d), .out_tag(o2_t), .out_illegal(o2_il));

  pipelined_shifter #(.WIDTH(32), .STAGES(1), .TAG_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x),
    .in_ready(rdy1), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(o1_v), .out_ready(one),
    .out_data(o1_d), .out_tag(o1_t), .out_illegal(o1_il));

  pipelined_shifter #(.WIDTH(32), .STAGES(5), .TAG_W(4)) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x),
    .in_ready(rdy5), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(o5_v), .out_ready(one),
    .out_data(o5_d), .out_tag(o5_t), .out_illegal(o5_il));

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string nm, input int stg,
                     input exp_t e, input logic [31:0] d,
                     input logic [3:0] t, input logic il);
    chk({nm, ".data"}, d, e.data);
    chk({nm, ".tag"}, {28'd0, t}, {28'd0, e.tag});
    chk({nm, ".ill"}, {31'd0, il}, {31'd0, e.ill});
    if (e.lat)
      chk({nm, ".lat"}, cyc - e.acc, stg);
  endtask

  task automatic unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s got=output want=none t=%0t",
             nm, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o2_v && out_ready) begin
      if (q2.size() == 0) unexpected("s2.extra");
      else begin
        e = q2.pop_front();
        cmp("s2", 2, e, o2_d, o2_t, o2_il);
      end
    end else if (rst_n && o2_v) begin
      chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
      if (q2.size() > 0) begin
        chk("bp.data", o2_d, q2[0].data);
        chk("bp.tag", {28'd0, o2_t}, {28'd0, q2[0].tag});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o1_v) begin
      if (q1.size() == 0) unexpected("s1.extra");
      else begin
        e = q1.pop_front();
        cmp("s1", 1, e, o1_d, o1_t, o1_il);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o5_v) begin
      if (q5.size() == 0) unexpected("s5.extra");
      else begin
        e = q5.pop_front();
        cmp("s5", 5, e, o5_d, o5_t, o5_il);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after accept.
  task automatic send(input logic [2:0] op,
                      input logic [31:0] d,
                      input logic [4:0] sh,
                      input logic [3:0] tg,
                      input logic [31:0] exp_d,
                      input bit x);
    exp_t e;
    bit acc = 0;
    int n = 0;
    in_op = op;
    in_data = d;
    in_shamt = sh;
    in_tag = tg;
    in_valid = 1;
    in_valid_x = x;
    e.data = exp_d;
    e.tag = tg;
    e.ill = (op > 3'b100);
    e.lat = lat_chk;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        e.acc = cyc;
        q2.push_back(e);
        if (x) begin
          chk("aux.in_ready", {30'd0, rdy1, rdy5}, 32'd3);
          q1.push_back(e);
          q5.push_back(e);
        end
        acc = 1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got=0 want=1");
    end
    in_valid = 0;
    in_valid_x = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    idle(3);
    chk("rst.valid", {31'd0, o2_v}, 32'd0);
    chk("rst.data", o2_d, 32'd0);
    chk("rst.tag", {28'd0, o2_t}, 32'd0);
    chk("rst.ill", {31'd0, o2_il}, 32'd0);
    rst_n = 1;
    idle(2);

    for (int n = 0; n < 32; n++)
      send(3'b000, ones, 5'(n), 4'(n), ones << n, 1);
    idle(8);

    send(3'b010, 32'h8000_0000, 31, 1, 32'hFFFF_FFFF, 1);
    send(3'b001, 32'h8000_0000, 31, 2, 32'h0000_0001, 1);
    send(3'b000, 32'h8000_0000, 31, 3, 32'h0000_0000, 1);
    send(3'b100, 32'h1234_5678, 8, 4, 32'h7812_3456, 1);
    send(3'b011, 32'h1234_5678, 4, 5, 32'h2345_6781, 1);
    send(3'b011, 32'h1234_5678, 0, 6, 32'h1234_5678, 1);
    send(3'b010, 32'hF000_000F, 4, 7, 32'hFF00_0000, 1);
    send(3'b001, 32'hF000_000F, 4, 8, 32'h0F00_0000, 1);
    send(3'b100, 32'h0000_0001, 31, 9, 32'h0000_0002, 1);
    send(3'b010, 32'h7000_0000, 3, 10, 32'h0E00_0000, 1);
    send(3'b111, 32'hDEAD_BEEF, 5, 11, 32'hDEAD_BEEF, 1);
    send(3'b101, 32'h0000_00F0, 2, 12, 32'h0000_00F0, 1);
    idle(8);

    lat_chk = 0;
    out_ready = 0;
    fork
      begin
        send(3'b001, 32'h0000_00F0, 1, 1, 32'h0000_0078, 0);
        send(3'b001, 32'h0000_00F0, 2, 2, 32'h0000_003C, 0);
        send(3'b001, 32'h0000_00F0, 3, 3, 32'h0000_001E, 0);
      end
      begin
        idle(6);
        out_ready = 1;
      end
    join
    idle(8);
    lat_chk = 1;

    send(3'b000, 32'h0000_0001, 1, 13, 32'h0000_0002, 1);
    send(3'b000, 32'h0000_0001, 2, 14, 32'h0000_0004, 1);
    rst_n = 0;
    #1;
    chk("rst2.v2", {31'd0, o2_v}, 32'd0);
    chk("rst2.v5", {31'd0, o5_v}, 32'd0);
    chk("rst2.data", o2_d, 32'd0);
    q2.delete();
    q1.delete();
    q5.delete();
    idle(2);
    rst_n = 1;
    idle(10);
    chk("post.v", {29'd0, o2_v, o1_v, o5_v}, 32'd0);

    chk("q2.left", q2.size(), 0);
    chk("q1.left", q1.size(), 0);
    chk("q5.left", q5.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
